// File: rtl/out_port_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module   : out_port_scheduler_if
//  Brief    : Bundle between the switch output queues, the output-side read
//             scheduler and the egress consumers. master = scheduler side,
//             slave = switch/consumer side.
//  Revision : 1.0 - initial release
// ============================================================================
interface out_port_scheduler_if #(
    parameter int PORT_NUB   = 4,
    parameter int DATA_WIDTH = 8
);
    localparam int WIDTH_SEL = $clog2(PORT_NUB);

    logic [PORT_NUB*PORT_NUB-1:0]   empty_in;
    logic [PORT_NUB*WIDTH_SEL-1:0]  rd_sel_out;
    logic [PORT_NUB-1:0]            rd_en_out;
    logic [PORT_NUB*DATA_WIDTH-1:0] data_in;
    logic [PORT_NUB*DATA_WIDTH-1:0] data_out;
    logic [PORT_NUB*WIDTH_SEL-1:0]  src_out;
    logic [PORT_NUB-1:0]            vld_out;
    logic [PORT_NUB-1:0]            ready_in;

    modport master (
        input  empty_in, data_in, ready_in,
        output rd_sel_out, rd_en_out, data_out, src_out, vld_out
    );

    modport slave (
        output empty_in, data_in, ready_in,
        input  rd_sel_out, rd_en_out, data_out, src_out, vld_out
    );
endinterface

`default_nettype wire

// File: rtl/out_port_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : out_port_scheduler
//  Brief    : Per-output round-robin burst read scheduler for the shared-memory
//             switch. Drives read select/enable into the per-source queues,
//             captures read data into a 2-entry skid buffer and presents it
//             with a valid/ready handshake plus source tag.
//  Options  : OUT_SCHED_BURST_EN - when defined, bursts run up to BURST_MAX
//             words; when undefined every grant is a single word.
//  Revision : 1.0 - initial release
// ============================================================================
module out_port_scheduler #(
    parameter int PORT_NUB   = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_MAX  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    out_port_scheduler_if.master bus
);
    localparam int WIDTH_SEL = $clog2(PORT_NUB);

`ifdef OUT_SCHED_BURST_EN
    localparam int c_burst_eff = BURST_MAX;
`else
    // Single-word grants: the effective burst limit clamps to one.
    localparam int c_burst_eff = (BURST_MAX < 1) ? BURST_MAX : 1;
`endif

    localparam int                 c_cnt_w   = $clog2(c_burst_eff + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_lim = c_cnt_w'(c_burst_eff);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    // Returns {found, index} of the first set bit of elig at or after start,
    // wrapping modulo PORT_NUB. Scanning from the far end lets the nearest
    // offset overwrite the result last.
    function automatic logic [WIDTH_SEL:0] pick_rr(
        input logic [WIDTH_SEL-1:0] start,
        input logic [PORT_NUB-1:0]  elig
    );
        logic [WIDTH_SEL:0]   res;
        logic [WIDTH_SEL-1:0] idx;
        res = '0;
        for (int k = PORT_NUB - 1; k >= 0; k--) begin
            idx = start + WIDTH_SEL'(k);
            if (elig[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < PORT_NUB; gi++) begin : g_out
            state_t                r_state;
            state_t                w_state_nxt;
            logic [WIDTH_SEL-1:0]  r_ptr;
            logic [WIDTH_SEL-1:0]  w_ptr_nxt;
            logic [WIDTH_SEL-1:0]  r_cur;
            logic [WIDTH_SEL-1:0]  w_cur_nxt;
            logic [c_cnt_w-1:0]    r_cnt;
            logic [c_cnt_w-1:0]    w_cnt_nxt;
            logic [WIDTH_SEL-1:0]  r_sel_hold;
            logic [WIDTH_SEL-1:0]  w_sel;
            logic [WIDTH_SEL-1:0]  w_sel_out;
            logic                  w_rd_en;
            logic                  w_issue;
            logic [PORT_NUB-1:0]   w_elig;
            logic [WIDTH_SEL:0]    w_pick;
            logic [2:0]            w_level;
            logic                  w_credit;
            logic                  w_push;
            logic                  w_pop;
            logic                  w_vld;

            logic                  r_inflight;
            logic [WIDTH_SEL-1:0]  r_inflight_src;
            logic [1:0]            r_occ;
            logic [DATA_WIDTH-1:0] r_mem_data [2];
            logic [WIDTH_SEL-1:0]  r_mem_src  [2];
            logic                  r_head;
            logic                  r_tail;

            // Eligible sources: non-empty queues, never the output's own port.
            always_comb begin
                for (int j = 0; j < PORT_NUB; j++) begin
                    w_elig[j] = ~bus.empty_in[gi*PORT_NUB + j] & (j != gi);
                end
            end

            // Credit: words already owed to the skid buffer (stored plus the
            // one in flight) less the word leaving this cycle must stay below 2.
            assign w_vld    = (r_occ != 2'd0);
            assign w_pop    = w_vld & bus.ready_in[gi];
            assign w_push   = r_inflight;
            assign w_level  = {1'b0, r_occ} + {2'b00, r_inflight};
            assign w_credit = (w_level - {2'b00, w_pop}) < 3'd2;

            // Arbitration and burst control: next state plus the read strobe.
            always_comb begin
                w_state_nxt = r_state;
                w_ptr_nxt   = r_ptr;
                w_cur_nxt   = r_cur;
                w_cnt_nxt   = r_cnt;
                w_rd_en     = 1'b0;
                w_sel       = r_sel_hold;
                w_pick      = pick_rr(r_ptr, w_elig);
                case (r_state)
                    ST_IDLE: begin
                        if (w_pick[WIDTH_SEL] && w_credit) begin
                            w_rd_en     = 1'b1;
                            w_sel       = w_pick[WIDTH_SEL-1:0];
                            w_cur_nxt   = w_pick[WIDTH_SEL-1:0];
                            w_cnt_nxt   = c_cnt_one;
                            w_state_nxt = ST_BURST;
                        end
                    end
                    ST_BURST: begin
                        if (!w_elig[r_cur] || (r_cnt == c_cnt_lim)) begin
                            // Burst boundary: rotate past the current source.
                            w_ptr_nxt   = r_cur + 1'b1;
                            w_cnt_nxt   = '0;
                            w_state_nxt = ST_IDLE;
                        end else if (w_credit) begin
                            w_rd_en   = 1'b1;
                            w_sel     = r_cur;
                            w_cnt_nxt = r_cnt + 1'b1;
                        end
                    end
                    default: begin
                        w_state_nxt = ST_IDLE;
                    end
                endcase
            end

            // The strobe is combinational, so it is forced low while reset is held.
            assign w_issue   = w_rd_en & ~rst;
            assign w_sel_out = w_issue ? w_sel : r_sel_hold;

            assign bus.rd_en_out[gi]                           = w_issue;
            assign bus.rd_sel_out[gi*WIDTH_SEL +: WIDTH_SEL]   = w_sel_out;
            assign bus.vld_out[gi]                             = w_vld;
            assign bus.data_out[gi*DATA_WIDTH +: DATA_WIDTH]   = r_mem_data[r_head];
            assign bus.src_out[gi*WIDTH_SEL +: WIDTH_SEL]      = r_mem_src[r_head];

            // Scheduler state register; the select is held between reads.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_state    <= ST_IDLE;
                    r_ptr      <= '0;
                    r_cur      <= '0;
                    r_cnt      <= '0;
                    r_sel_hold <= '0;
                end else begin
                    r_state    <= w_state_nxt;
                    r_ptr      <= w_ptr_nxt;
                    r_cur      <= w_cur_nxt;
                    r_cnt      <= w_cnt_nxt;
                    r_sel_hold <= w_sel_out;
                end
            end

            // Skid buffer: capture the word returned one cycle after each read.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_inflight     <= 1'b0;
                    r_inflight_src <= '0;
                    r_occ          <= 2'd0;
                    r_head         <= 1'b0;
                    r_tail         <= 1'b0;
                    for (int k = 0; k < 2; k++) begin
                        r_mem_data[k] <= '0;
                        r_mem_src[k]  <= '0;
                    end
                end else begin
                    r_inflight     <= w_issue;
                    r_inflight_src <= w_sel_out;
                    if (w_push) begin
                        r_mem_data[r_tail] <= bus.data_in[gi*DATA_WIDTH +: DATA_WIDTH];
                        r_mem_src[r_tail]  <= r_inflight_src;
                        r_tail             <= ~r_tail;
                    end
                    if (w_pop) begin
                        r_head <= ~r_head;
                    end
                    r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
                end
            end

            a_no_overflow : assert property (@(posedge clk) disable iff (rst)
                !(w_push && !w_pop && (r_occ == 2'd2)));
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_out_port_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_out_port_scheduler
//  Brief    : Self-checking bench. A queue-level switch model supplies data and
//             empty flags; a reference model predicts each output's word
//             stream from the round-robin burst rules.
//  Options  : OUT_SCHED_BURST_EN selects the expected burst length.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_out_port_scheduler;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int BM = 4;
    localparam int WS = 2;
`ifdef OUT_SCHED_BURST_EN
    localparam int EFF = BM;
`else
    localparam int EFF = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    out_port_scheduler_if #(.PORT_NUB(N), .DATA_WIDTH(DW)) bus ();

    out_port_scheduler #(
        .PORT_NUB   (N),
        .DATA_WIDTH (DW),
        .BURST_MAX  (BM)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Switch queue contents and reference state
    logic [DW-1:0]    q     [N][N][$];
    logic [WS+DW-1:0] exp_w [N][$];
    int               mptr [N];
    int               rd_idx [N];
    int               del_idx [N];
    int               outst [N];
    int               max_outst [N];
    int               hold_cnt [N];
    logic             pend_v [N];
    logic [DW-1:0]    pend_d [N];
    bit               trace_on;
    bit               trace_started;
    int               trace_total;
    int               tr [$];

    task automatic load(input int i, input int j, input int n, input int base);
        for (int t = 0; t < n; t++) begin
            if (base >= 0) q[i][j].push_back(DW'(base + t));
            else           q[i][j].push_back(DW'($urandom));
        end
    endtask

    // Reference: rotate over non-empty sources from the pointer, taking up to
    // EFF words from each, then moving the pointer past that source.
    task automatic build_model(input int i);
        int pos [N];
        int sel;
        int k;
        int j;
        bit found;
        for (int s = 0; s < N; s++) pos[s] = 0;
        sel = 0;
        do begin
            found = 0;
            for (int o = 0; o < N; o++) begin
                j = (mptr[i] + o) % N;
                if (!found && j != i && pos[j] < q[i][j].size()) begin
                    found = 1;
                    sel   = j;
                end
            end
            if (found) begin
                k = q[i][sel].size() - pos[sel];
                if (k > EFF) k = EFF;
                for (int t = 0; t < k; t++)
                    exp_w[i].push_back({WS'(sel), q[i][sel][pos[sel] + t]});
                pos[sel] += k;
                mptr[i] = (sel + 1) % N;
            end
        end while (found);
    endtask

    task automatic clear_phase();
        for (int i = 0; i < N; i++) begin
            exp_w[i].delete();
            rd_idx[i]    = 0;
            del_idx[i]   = 0;
            max_outst[i] = 0;
            hold_cnt[i]  = 0;
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_rden"}, bus.rd_en_out, 0);
        chk({tag, "_rdsel"}, bus.rd_sel_out, 0);
        chk({tag, "_vld"}, bus.vld_out, 0);
        chk({tag, "_data"}, bus.data_out, 0);
        chk({tag, "_src"}, bus.src_out, 0);
    endtask

    // One clock: drive switch-side inputs after the edge, then sample outputs.
    // ready modes: 0 all high, 1 random, 2 output-1 hold window, 3 output 1 low.
    task automatic do_cycle(input int mode);
        logic             p;
        logic [WS-1:0]    s;
        logic [WS+DW-1:0] e;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            bus.data_in[i*DW +: DW] = pend_v[i] ? pend_d[i] : DW'($urandom);
            pend_v[i] = 1'b0;
            for (int j = 0; j < N; j++)
                bus.empty_in[i*N + j] = (q[i][j].size() == 0);
            case (mode)
                0: bus.ready_in[i] = 1'b1;
                1: bus.ready_in[i] = ($urandom_range(3) != 0);
                2: begin
                    if (i == 1 && hold_cnt[i] > 0) begin
                        bus.ready_in[i] = 1'b0;
                        hold_cnt[i]--;
                    end else begin
                        bus.ready_in[i] = 1'b1;
                    end
                end
                default: bus.ready_in[i] = (i != 1);
            endcase
        end
        #1;
        for (int i = 0; i < N; i++) begin
            p = bus.vld_out[i] & bus.ready_in[i];
            if (p) begin
                if (del_idx[i] < exp_w[i].size()) begin
                    e = exp_w[i][del_idx[i]];
                    chk("data", bus.data_out[i*DW +: DW], e[DW-1:0]);
                    chk("src", bus.src_out[i*WS +: WS], e[WS+DW-1:DW]);
                end else begin
                    chk("extra_word", 1, 0);
                end
                del_idx[i]++;
            end
            if (trace_on && i == 0 && (bus.rd_en_out[0] || trace_started) && rd_idx[0] < trace_total) begin
                tr.push_back(int'(bus.rd_en_out[0]));
                trace_started = 1;
            end
            if (bus.rd_en_out[i]) begin
                chk("credit", ((outst[i] - int'(p)) < 2), 1);
                s = bus.rd_sel_out[i*WS +: WS];
                if (rd_idx[i] < exp_w[i].size()) begin
                    e = exp_w[i][rd_idx[i]];
                    chk("grant", s, e[WS+DW-1:DW]);
                end else begin
                    chk("extra_read", 1, 0);
                end
                if (q[i][s].size() > 0) pend_d[i] = q[i][s].pop_front();
                else                    pend_d[i] = '0;
                pend_v[i] = 1'b1;
                rd_idx[i]++;
                outst[i]++;
                if (mode == 2 && i == 1 && rd_idx[i] == 2) hold_cnt[i] = 5;
            end
            if (p) outst[i]--;
            if (outst[i] > max_outst[i]) max_outst[i] = outst[i];
        end
    endtask

    task automatic run_phase(input int mode, input int budget);
        int cyc;
        bit done;
        cyc = 0;
        do begin
            do_cycle(mode);
            cyc++;
            done = 1;
            for (int i = 0; i < N; i++)
                if (del_idx[i] < exp_w[i].size() || outst[i] != 0) done = 0;
        end while (!done && cyc < budget);
        if (!done) chk("timeout", 0, 1);
        for (int i = 0; i < N; i++) chk("count", del_idx[i], exp_w[i].size());
        do_cycle(0);
        do_cycle(0);
    endtask

    initial begin
        int rem;
        int k;
        int et [$];

        bus.empty_in = '1;
        bus.ready_in = '0;
        bus.data_in  = '0;
        for (int i = 0; i < N; i++) begin
            mptr[i]   = 0;
            outst[i]  = 0;
            pend_v[i] = 1'b0;
            pend_d[i] = '0;
        end
        trace_on = 0;
        trace_started = 0;
        trace_total = 0;

        // Reset state
        rst = 1'b1;
        #1;
        check_zero("reset");
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;

        // All queues empty: nothing read, nothing valid
        clear_phase();
        for (int c = 0; c < 20; c++) begin
            do_cycle(0);
            chk("idle_rden", bus.rd_en_out, 0);
            chk("idle_vld", bus.vld_out, 0);
        end

        // Single-source bursts, three-source rotation, two-source alternation
        clear_phase();
        load(0, 1, 6, 'h10);
        load(2, 0, 2, 'h20);
        load(2, 1, 2, 'h24);
        load(2, 3, 2, 'h28);
        load(3, 0, 3, 'h30);
        load(3, 1, 3, 'h38);
        for (int i = 0; i < N; i++) build_model(i);
        trace_on = 1;
        trace_started = 0;
        trace_total = exp_w[0].size();
        tr.delete();
        run_phase(0, 200);
        trace_on = 0;
        rem = 6;
        while (rem > 0) begin
            k = (rem > EFF) ? EFF : rem;
            for (int t = 0; t < k; t++) et.push_back(1);
            rem -= k;
            if (rem > 0) et.push_back(0);
        end
        chk("trace_len", tr.size(), et.size());
        for (int t = 0; t < et.size() && t < tr.size(); t++) chk("trace", tr[t], et[t]);

        // Back-pressure on output 1 after its second read
        clear_phase();
        load(1, 0, 8, 'h40);
        build_model(1);
        run_phase(2, 200);
        chk("peak_occ", max_outst[1], 2);

        // Randomized loads with random back-pressure
        for (int it = 0; it < 4; it++) begin
            clear_phase();
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    if (j != i && $urandom_range(1) == 1) load(i, j, $urandom_range(1, 5), -1);
            for (int i = 0; i < N; i++) build_model(i);
            run_phase(1, 1000);
        end

        // Asynchronous reset mid-burst with one word stored and one in flight
        clear_phase();
        load(1, 2, 4, 'h50);
        build_model(1);
        begin
            int c;
            c = 0;
            while (rd_idx[1] < 2 && c < 20) begin
                do_cycle(3);
                c++;
            end
            if (rd_idx[1] < 2) chk("pre_reset_reads", rd_idx[1], 2);
        end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_zero("midrst");
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) q[i][j].delete();
            mptr[i]   = 0;
            outst[i]  = 0;
            pend_v[i] = 1'b0;
        end
        bus.empty_in = '1;
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        clear_phase();
        load(1, 0, 2, 'h60);
        load(1, 2, 2, 'h64);
        load(0, 1, 2, 'h70);
        load(0, 3, 2, 'h74);
        build_model(0);
        build_model(1);
        run_phase(0, 200);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", n_chk, n_bad);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/out_port_scheduler.md
Name: out_port_scheduler

Overview:
- Output-side read scheduler for the shared-memory switch.
- Each output port owns a bank of per-source queues in the switch. For each output port, this block arbitrates round-robin, in bursts, among those non-empty queues.
- It drives the switch's per-port read-select and read-enable, and captures the read data into a 2-entry skid buffer.
- It presents the data to the downstream consumer with a valid/ready handshake plus a source tag.
- It sits directly between the switch's output queues and the egress MACs.

Parameters:
PORT_NUB, 4, number of switch ports N (power of two, >=2); WIDTH_SEL = $clog2(PORT_NUB)
DATA_WIDTH, 8, word width of the switch output data
BURST_MAX, 4, maximum consecutive words read from one source queue before rotating (>=1)

Ports:
clk  input  1  clock; all state on rising edge
rst  input  1  asynchronous, active-high reset
empty_in  input  N*N  bit [i*N+j] = 1 when output i's queue for source j is empty; registered in switch, reflects a read one cycle after rd_en
rd_sel_out  output  N*WIDTH_SEL  per-output source-queue select to switch
rd_en_out  output  N  per-output read strobe to switch
data_in  input  N*DATA_WIDTH  switch read data; valid exactly 1 cycle after rd_en_out[i]
data_out  output  N*DATA_WIDTH  skid-buffer head per output
src_out  output  N*WIDTH_SEL  source port of data_out word
vld_out  output  N  data_out/src_out valid
ready_in  input  N  downstream accept; a word transfers when vld_out[i] & ready_in[i]

Behaviour:
- Reset: rd_en_out=0, rd_sel_out=0, vld_out=0, data_out=0, src_out=0. Each output is placed in IDLE with ptr=0, cnt=0, occ=0, inflight=0.
- Output ports are fully independent; the logic below is replicated per output i.
- Eligible source j: empty_in[i*N+j]==0 and j!=i. The self queue is always masked.
- Credit: a read is allowed when occ + inflight - pop < 2.
  - occ = skid-buffer occupancy (0..2).
  - inflight = rd_en_out[i] registered from the previous cycle.
  - pop = vld_out[i] & ready_in[i].
- FSM states: IDLE and BURST.
  - IDLE: if any source is eligible and credit is allowed, grant the first eligible source at or after ptr (wrapping mod N). The same cycle, assert rd_en_out=1 and rd_sel_out=winner; set cur=winner, cnt=1, and go to BURST. Otherwise rd_en_out=0.
  - BURST, continue case: cur eligible, credit allowed and cnt<BURST_MAX. Assert rd_en_out with rd_sel_out=cur and increment cnt.
  - BURST, credit-only stall: cur eligible, credit not allowed and cnt<BURST_MAX. Hold state and cnt; rd_en_out=0.
  - BURST, terminate: cur empty or cnt==BURST_MAX. rd_en_out=0; set ptr=(cur+1) mod N, cnt=0, and go to IDLE. This costs one bubble cycle per burst boundary.
- rd_en_out is combinational from registered state, empty_in, occ and ready_in. rd_sel_out holds its last value when rd_en_out=0.
- Capture: when inflight=1, data_in[i] is pushed into the skid buffer along with the source tag registered at issue.
  - Push and pop can occur in the same cycle; occ is then unchanged.
  - The credit rule guarantees occ never exceeds 2. Overflow is an assertion failure.
- Output: vld_out = (occ>0). data_out/src_out show the FIFO head and are held stable while vld_out=1 and ready_in=0.
- Throughput: sustains one word per cycle per output within a burst while ready_in=1.
- Ordering: words from one source are delivered in read order. Different sources interleave only at burst boundaries.
- Mid-operation reset: any in-flight read word is discarded and the skid buffer is cleared. The word is lost; the upper level must quiesce the switch before reset.

Optional Feature:
- Macro: OUT_SCHED_BURST_EN.
- Defined: BURST_MAX governs burst length as described.
- Undefined: the effective BURST_MAX is 1. Every grant rotates ptr, giving pure per-word round-robin; the FSM always returns to IDLE after one read, so each word carries one bubble.

Test Plan:
- N=4, DATA_WIDTH=8, BURST_MAX=4. Output 0 has source 1 with 6 words (0x10..0x15) and ready high.
  - Expect reads 1,1,1,1, then a bubble, then 1,1.
  - Expect vld_out[0] words 0x10..0x15 in order with src_out=1.
- Output 2 has sources 0, 1 and 3 non-empty with 2 words each and ready high.
  - Expect grant order 0,1,3; source 2 is never read; 6 words delivered.
- Output 1 has source 0 with 8 words. ready_in[1] is held low for 5 cycles starting on the 2nd read.
  - Expect occ to peak at 2 and no further rd_en.
  - On ready release, all 8 words are delivered in order; none lost or duplicated.
- All queues empty: empty_in all 1, ready high for 20 cycles.
  - Expect rd_en_out=0 and vld_out=0 throughout; ptr stays 0.
- rst pulsed asynchronously mid-burst, with one word in flight and occ=1.
  - Expect all outputs 0 immediately and the FSM back in IDLE.
  - After release, arbitration restarts at source 0 (or source 1 if the output is 0).
- OUT_SCHED_BURST_EN undefined; output 3 has sources 0 and 1 with 3 words each.
  - Expect grant sequence 0,1,0,1,0,1.
